// File: rtl/run_detect_scheduler.sv
// Round-robin scheduler that time-shares one external run detector between two requesters,
// serialising each granted word MSB first and collecting hit statistics from det_z_i.
module run_detect_scheduler #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = 3,
    parameter int unsigned CNTW  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic [1:0]       grant_o,
    output logic             busy_o,
    output logic             det_clr_o,
    output logic             det_en_o,
    output logic             det_w_o,
    input  logic             det_z_i,
    output logic             done_o,
    output logic             done_id_o,
    output logic [CNTW-1:0]  hit_count_o,
    output logic [IDXW-1:0]  first_hit_o,
    output logic             first_vld_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_CHECK,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic             rr_last_q;
    logic             id_q;
    logic             win;
    logic [WIDTH-1:0] shreg_q;
    logic [IDXW-1:0]  idx_q;
    logic             last_bit;

    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [IDXW-1:0]  fhit_q, fhit_d;
    logic             fvld_q, fvld_d;

    logic             res_id_q;
    logic [CNTW-1:0]  res_cnt_q;
    logic [IDXW-1:0]  res_fhit_q;
    logic             res_fvld_q;

    // Sole requester wins outright; on a tie the one not served last time wins.
    always_comb begin
        win = ~rr_last_q;
        if (req_i == 2'b01)      win = 1'b0;
        else if (req_i == 2'b10) win = 1'b1;
    end

    assign last_bit = (idx_q == IDXW'(WIDTH - 1));

    always_comb begin
        cnt_d  = cnt_q;
        fhit_d = fhit_q;
        fvld_d = fvld_q;
        if (det_z_i) begin
            if (!fvld_q) begin
                fhit_d = idx_q;
                fvld_d = 1'b1;
            end
            if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (req_i != 2'b00) state_d = S_CLEAR;
            S_CLEAR: state_d = S_SHIFT;
            S_SHIFT: state_d = S_CHECK;
            S_CHECK: state_d = last_bit ? S_DONE : S_SHIFT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_o   = '0;
        busy_o    = (state_q != S_IDLE);
        det_clr_o = (state_q == S_CLEAR);
        det_en_o  = (state_q == S_SHIFT);
        det_w_o   = (state_q == S_SHIFT) && shreg_q[WIDTH-1];
        done_o    = (state_q == S_DONE);
        if (state_q != S_IDLE) grant_o = id_q ? 2'b10 : 2'b01;
    end

    // Accumulators run during the job; result registers only load on entry to DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_last_q  <= 1'b1;
            id_q       <= 1'b0;
            shreg_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            fhit_q     <= '0;
            fvld_q     <= 1'b0;
            res_id_q   <= 1'b0;
            res_cnt_q  <= '0;
            res_fhit_q <= '0;
            res_fvld_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_i != 2'b00) begin
                        id_q      <= win;
                        rr_last_q <= win;
                        shreg_q   <= win ? data1_i : data0_i;
                        idx_q     <= '0;
                        cnt_q     <= '0;
                        fhit_q    <= '0;
                        fvld_q    <= 1'b0;
                    end
                end
                S_SHIFT: shreg_q <= shreg_q << 1;
                S_CHECK: begin
                    cnt_q  <= cnt_d;
                    fhit_q <= fhit_d;
                    fvld_q <= fvld_d;
                    if (last_bit) begin
                        res_id_q   <= id_q;
                        res_cnt_q  <= cnt_d;
                        res_fhit_q <= fhit_d;
                        res_fvld_q <= fvld_d;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_id_o   = res_id_q;
    assign hit_count_o = res_cnt_q;
    assign first_hit_o = res_fhit_q;
    assign first_vld_o = res_fvld_q;

endmodule

// File: tb/tb_run_detect_scheduler.sv
// Bench for run_detect_scheduler: two instances (CNTW=4 and CNTW=2) in lockstep, each driving
// its own run-of-4 detector model, checked against a timeline-level reference model.
module tb_run_detect_scheduler;

    localparam int W   = 8;
    localparam int RUN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;

    logic [1:0] grant;
    logic       busy, det_clr, det_en, det_w, det_z, done, done_id, first_vld;
    logic [3:0] hit_count;
    logic [2:0] first_hit;

    logic [1:0] grant2;
    logic       busy2, det_clr2, det_en2, det_w2, det_z2, done2, done_id2, first_vld2;
    logic [1:0] hit_count2;
    logic [2:0] first_hit2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    run_detect_scheduler #(.WIDTH(8), .IDXW(3), .CNTW(4)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data0_i(data0), .data1_i(data1),
        .grant_o(grant), .busy_o(busy), .det_clr_o(det_clr), .det_en_o(det_en),
        .det_w_o(det_w), .det_z_i(det_z), .done_o(done), .done_id_o(done_id),
        .hit_count_o(hit_count), .first_hit_o(first_hit), .first_vld_o(first_vld)
    );

    run_detect_scheduler #(.WIDTH(8), .IDXW(3), .CNTW(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data0_i(data0), .data1_i(data1),
        .grant_o(grant2), .busy_o(busy2), .det_clr_o(det_clr2), .det_en_o(det_en2),
        .det_w_o(det_w2), .det_z_i(det_z2), .done_o(done2), .done_id_o(done_id2),
        .hit_count_o(hit_count2), .first_hit_o(first_hit2), .first_vld_o(first_vld2)
    );

    // External detectors: z=1 once the last RUN bits since clear are all equal.
    logic [3:0] h0 = 4'h0, h1 = 4'h0;
    int         n0 = 0, n1 = 0;
    always @(posedge clk) begin
        if (det_clr) begin h0 <= 4'h0; n0 <= 0; end
        else if (det_en) begin h0 <= {h0[2:0], det_w}; n0 <= (n0 < RUN) ? n0 + 1 : RUN; end
        if (det_clr2) begin h1 <= 4'h0; n1 <= 0; end
        else if (det_en2) begin h1 <= {h1[2:0], det_w2}; n1 <= (n1 < RUN) ? n1 + 1 : RUN; end
    end
    assign det_z  = (n0 >= RUN) && (h0 == 4'hF || h0 == 4'h0);
    assign det_z2 = (n1 >= RUN) && (h1 == 4'hF || h1 == 4'h0);

    typedef struct packed {
        logic [3:0] hits;
        logic [2:0] first;
        logic       vld;
    } res_t;

    function automatic res_t job_result(input logic [7:0] w);
        res_t r;
        int   hits;
        r    = '0;
        hits = 0;
        for (int i = RUN - 1; i < W; i++) begin
            bit same;
            same = 1'b1;
            for (int j = 1; j < RUN; j++)
                if (w[7 - i + j] != w[7 - i]) same = 1'b0;
            if (same) begin
                if (!r.vld) begin r.first = 3'(i); r.vld = 1'b1; end
                hits++;
            end
        end
        r.hits = 4'(hits);
        return r;
    endfunction

    function automatic logic pick(input logic [1:0] r, input logic last);
        if (r == 2'b01) return 1'b0;
        if (r == 2'b10) return 1'b1;
        return ~last;
    endfunction

    // Reference model: t counts cycles since acceptance (1 = grant/clear, 2W+2 = done).
    logic       mbusy, mrr, mid;
    logic [7:0] mword;
    res_t       mres;
    int         t;
    logic       r_id, r_vld;
    logic [3:0] r_cnt4;
    logic [1:0] r_cnt2;
    logic [2:0] r_first;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mbusy <= 1'b0; t <= 0; mrr <= 1'b1; mid <= 1'b0; mword <= 8'h00; mres <= '0;
            r_id <= 1'b0; r_cnt4 <= 4'h0; r_cnt2 <= 2'h0; r_first <= 3'h0; r_vld <= 1'b0;
        end else if (!mbusy) begin
            if (req != 2'b00) begin
                mid   <= pick(req, mrr);
                mrr   <= pick(req, mrr);
                mword <= pick(req, mrr) ? data1 : data0;
                mres  <= job_result(pick(req, mrr) ? data1 : data0);
                mbusy <= 1'b1;
                t     <= 1;
            end
        end else if (t == 2 * W + 2) begin
            mbusy <= 1'b0;
            t     <= 0;
        end else begin
            t <= t + 1;
            if (t + 1 == 2 * W + 2) begin
                r_id    <= mid;
                r_cnt4  <= mres.hits;
                r_cnt2  <= (mres.hits > 4'd3) ? 2'd3 : mres.hits[1:0];
                r_first <= mres.first;
                r_vld   <= mres.vld;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            int  e_grant;
            bit  e_en;
            e_grant = mbusy ? (mid ? 2 : 1) : 0;
            e_en    = mbusy && t >= 2 && t <= 2 * W && (t % 2 == 0);
            chk("m_grant",   grant,   e_grant);
            chk("m_busy",    busy,    mbusy);
            chk("m_det_clr", det_clr, mbusy && t == 1);
            chk("m_det_en",  det_en,  e_en);
            if (e_en) chk("m_det_w", det_w, mword[7 - (t - 2) / 2]);
            chk("m_done",    done,    mbusy && t == 2 * W + 2);
            chk("m_done_id", done_id, r_id);
            chk("m_hits",    hit_count, r_cnt4);
            chk("m_first",   first_hit, r_first);
            chk("m_vld",     first_vld, r_vld);
            chk("m_hits_sat", hit_count2, r_cnt2);
            chk("m_done2",   done2,   done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the IDLE cycle where req is seen; returns cycles until done.
    task automatic wait_done(input bit mutate, output int ticks, output logic [1:0] g,
                             output int nclr, output int nen);
        ticks = 0; g = 2'b00; nclr = 0; nen = 0;
        do begin
            tick();
            ticks++;
            if (ticks == 1) g = grant;
            if (mutate && ticks == 2) begin req = 2'b00; data0 = 8'h00; end
            if (det_clr) nclr++;
            if (det_en) nen++;
        end while (!done && ticks < 60);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int         ticks, nclr, nen, nd;
        logic [1:0] g;
        logic [1:0] exp_g [3];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;

        #2;
        chk("rst_grant", grant, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_hits",  hit_count, 0);
        tick();
        rst = 1'b0;
        tick();

        // Job 1: requester 0, F0
        req = 2'b01; data0 = 8'hF0;
        wait_done(1'b0, ticks, g, nclr, nen);
        chk("j1_latency", ticks, 18);
        chk("j1_grant", g, 2'b01);
        chk("j1_id", done_id, 0);
        chk("j1_hits", hit_count, 2);
        chk("j1_first", first_hit, 3);
        chk("j1_vld", first_vld, 1);
        req = 2'b00;
        tick();

        // Job 2: requester 1, FF then AA
        req = 2'b10; data1 = 8'hFF;
        wait_done(1'b0, ticks, g, nclr, nen);
        chk("j2_id", done_id, 1);
        chk("j2_hits", hit_count, 5);
        chk("j2_first", first_hit, 3);
        tick();
        data1 = 8'hAA;
        wait_done(1'b0, ticks, g, nclr, nen);
        chk("j2b_hits", hit_count, 0);
        chk("j2b_vld", first_vld, 0);
        chk("j2b_first", first_hit, 0);
        req = 2'b00;
        tick();

        // Both requesting for three jobs
        data0 = 8'h0F; data1 = 8'h3C; req = 2'b11;
        for (int j = 0; j < 3; j++) begin
            wait_done(1'b0, ticks, g, nclr, nen);
            chk("rr_grant", g, exp_g[j]);
            chk("rr_latency", ticks, 18);
            tick();
            chk("rr_gap_grant", grant, 0);
        end
        req = 2'b00;
        tick();
        tick();

        // Inputs change mid-job
        req = 2'b01; data0 = 8'hE1;
        wait_done(1'b1, ticks, g, nclr, nen);
        chk("mut_clr_cycles", nclr, 1);
        chk("mut_en_cycles", nen, 8);
        chk("mut_hits", hit_count, 1);
        chk("mut_first", first_hit, 6);
        tick();

        // Reset during SHIFT of bit 5
        req = 2'b01; data0 = 8'hFF;
        for (int k = 0; k < 12; k++) begin
            tick();
            req = 2'b00;
        end
        chk("pre_rst_en", det_en, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_grant", grant, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_en", det_en, 0);
        chk("rst_mid_hits", hit_count, 0);
        chk("rst_mid_vld", first_vld, 0);
        tick();
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) nd++;
        end
        chk("rst_no_done", nd, 0);
        req = 2'b10; data1 = 8'h81;
        wait_done(1'b0, ticks, g, nclr, nen);
        chk("post_rst_id", done_id, 1);
        chk("post_rst_hits", hit_count, 3);
        chk("post_rst_first", first_hit, 4);
        req = 2'b00;
        tick();

        // Saturation on the CNTW=2 instance
        req = 2'b01; data0 = 8'h00;
        wait_done(1'b0, ticks, g, nclr, nen);
        chk("sat_raw_hits", hit_count, 5);
        chk("sat_hits", hit_count2, 3);
        chk("sat_first", first_hit2, 3);
        req = 2'b00;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
